// File: rtl/mem_arbiter.sv
// Round-robin sequencer sharing one fixed-latency memory between the fetch (I) and data (D) ports.
// One transaction at a time: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP -> IDLE.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_ack,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        owner
);

  localparam int unsigned CntW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_owner;
  logic            r_wr;
  logic [15:0]     r_addr;
  logic [15:0]     r_wdata;
  logic [15:0]     r_i_rdata;
  logic [15:0]     r_d_rdata;
  logic            r_i_ack;
  logic            r_d_ack;
  logic            r_mem_en;
  logic            r_mem_wr;
  logic [15:0]     r_mem_addr;
  logic [15:0]     r_mem_wdata;

  logic            w_any_req;
  logic            w_grant_d;
  logic            w_wr;
  logic [15:0]     w_addr;
  logic [15:0]     w_wdata;

  // On a tie, D wins unless it won the previous grant.
  always_comb begin
    w_any_req = i_req | d_req;
    w_grant_d = d_req & (~i_req | ~r_owner);
    w_wr      = w_grant_d & d_wr;
    w_addr    = w_grant_d ? d_addr : i_addr;
    w_wdata   = w_grant_d ? d_wdata : 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_owner     <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= 16'h0000;
      r_wdata     <= 16'h0000;
      r_i_rdata   <= 16'h0000;
      r_d_rdata   <= 16'h0000;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= 16'h0000;
      r_mem_wdata <= 16'h0000;
    end else begin
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= 16'h0000;
      r_mem_wdata <= 16'h0000;
      unique case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_owner     <= w_grant_d;
            r_wr        <= w_wr;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            // Command outputs are registered, so they are set up here to appear in ISSUE.
            r_mem_en    <= 1'b1;
            r_mem_wr    <= w_wr;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_wdata;
            r_state     <= StIssue;
          end
        end
        StIssue: begin
          r_cnt   <= CntW'(MEM_LAT);
          r_state <= StWait;
        end
        StWait: begin
          if (r_cnt == CntW'(1)) begin
            if (!r_wr) begin
              if (r_owner) r_d_rdata <= mem_rdata;
              else         r_i_rdata <= mem_rdata;
            end
            r_i_ack <= ~r_owner;
            r_d_ack <= r_owner;
            r_cnt   <= '0;
            r_state <= StResp;
          end else begin
            r_cnt <= r_cnt - CntW'(1);
          end
        end
        StResp: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign i_ack     = r_i_ack;
  assign d_ack     = r_d_ack;
  assign mem_en    = r_mem_en;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != StIdle);
  assign owner     = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single read/write, tie, round-robin, reset mid-transaction.
// A small fixed-latency memory model drives mem_rdata only in the valid cycle.
module tb_mem_arbiter;

  localparam int unsigned Lat = 4;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic [15:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_ack;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        owner;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.MEM_LAT(Lat)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ack     (i_ack),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: data valid only Lat cycles after the mem_en cycle; 0xDEAD otherwise.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0010: mem_word = 16'hA5A5;
      16'h0030: mem_word = 16'h3333;
      16'h0040: mem_word = 16'h4444;
      16'h0050: mem_word = 16'hBEEF;
      16'h0060: mem_word = 16'h6060;
      default:  mem_word = a ^ 16'h5A5A;
    endcase
  endfunction

  int          m_k = 0;
  logic [15:0] m_addr = 16'h0000;

  always @(posedge clk) begin
    if (mem_en) begin
      m_k    <= 1;
      m_addr <= mem_addr;
    end else if (m_k != 0 && m_k <= Lat) begin
      m_k <= m_k + 1;
    end
  end

  assign mem_rdata = (m_k == Lat) ? mem_word(m_addr) : 16'hDEAD;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    i_req   = 1'b0;
    i_addr  = 16'h0000;
    d_req   = 1'b0;
    d_wr    = 1'b0;
    d_addr  = 16'h0000;
    d_wdata = 16'h0000;

    // Reset held for 2 cycles with random requests
    for (int c = 0; c < 2; c++) begin
      i_req   = 1'($urandom_range(0, 1));
      d_req   = 1'($urandom_range(0, 1));
      d_wr    = 1'($urandom_range(0, 1));
      i_addr  = 16'($urandom);
      d_addr  = 16'($urandom);
      d_wdata = 16'($urandom);
      tick();
      chk($sformatf("rst c%0d data", c), {i_rdata, d_rdata, mem_addr, mem_wdata}, 64'h0);
      chk($sformatf("rst c%0d ctl", c), 64'({i_ack, d_ack, mem_en, mem_wr, busy, owner}), 64'h0);
    end
    rst   = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    d_wr  = 1'b0;
    tick();
    chk("idle busy", 64'(busy), 64'h0);

    // Single I read
    i_req  = 1'b1;
    i_addr = 16'h0010;
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk($sformatf("iread c%0d mem_en", c), 64'(mem_en), 64'(c == 1));
      chk($sformatf("iread c%0d mem_wr", c), 64'(mem_wr), 64'h0);
      chk($sformatf("iread c%0d mem_addr", c), 64'(mem_addr), (c == 1) ? 64'h10 : 64'h0);
      chk($sformatf("iread c%0d i_ack", c), 64'(i_ack), 64'(c == 6));
      chk($sformatf("iread c%0d d_ack", c), 64'(d_ack), 64'h0);
      chk($sformatf("iread c%0d busy", c), 64'(busy), 64'(c <= 6));
      if (c == 6) begin
        chk("iread rdata", 64'(i_rdata), 64'hA5A5);
        i_req = 1'b0;
      end
    end

    // D write
    d_req   = 1'b1;
    d_wr    = 1'b1;
    d_addr  = 16'h0020;
    d_wdata = 16'h1234;
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk($sformatf("dwr c%0d cmd", c), 64'({mem_en, mem_wr}), (c == 1) ? 64'h3 : 64'h0);
      chk($sformatf("dwr c%0d addr/wdata", c), 64'({mem_addr, mem_wdata}),
          (c == 1) ? 64'h0020_1234 : 64'h0);
      chk($sformatf("dwr c%0d d_ack", c), 64'(d_ack), 64'(c == 6));
      chk($sformatf("dwr c%0d d_rdata", c), 64'(d_rdata), 64'h0);
      chk($sformatf("dwr c%0d owner", c), 64'(owner), 64'h1);
      if (c == 6) d_req = 1'b0;
    end
    d_wr = 1'b0;

    // Tie after reset: D first, then I
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("tie owner after rst", 64'(owner), 64'h0);
    i_req  = 1'b1;
    i_addr = 16'h0040;
    d_req  = 1'b1;
    d_addr = 16'h0030;
    for (int c = 1; c <= 14; c++) begin
      tick();
      chk($sformatf("tie c%0d mem_en", c), 64'(mem_en), 64'(c == 1 || c == 8));
      chk($sformatf("tie c%0d mem_addr", c), 64'(mem_addr),
          (c == 1) ? 64'h30 : ((c == 8) ? 64'h40 : 64'h0));
      chk($sformatf("tie c%0d d_ack", c), 64'(d_ack), 64'(c == 6));
      chk($sformatf("tie c%0d i_ack", c), 64'(i_ack), 64'(c == 13));
      chk($sformatf("tie c%0d owner", c), 64'(owner), 64'(c >= 1 && c <= 7));
      if (c >= 6) chk($sformatf("tie c%0d d_rdata", c), 64'(d_rdata), 64'h3333);
      if (c == 13) chk("tie i_rdata", 64'(i_rdata), 64'h4444);
      if (d_ack) d_req = 1'b0;
      if (i_ack) i_req = 1'b0;
    end

    // Round-robin: both held high for 4 grants, last grant was I so D leads
    i_req = 1'b1;
    d_req = 1'b1;
    for (int c = 1; c <= 28; c++) begin
      tick();
      chk($sformatf("rr c%0d mem_en", c), 64'(mem_en), 64'(c == 1 || c == 8 || c == 15 || c == 22));
      chk($sformatf("rr c%0d d_ack", c), 64'(d_ack), 64'(c == 6 || c == 20));
      chk($sformatf("rr c%0d i_ack", c), 64'(i_ack), 64'(c == 13 || c == 27));
      if (c == 27) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end
    end
    tick();
    chk("rr idle busy", 64'(busy), 64'h0);

    // Reset in cycle 3 of a D read
    d_req  = 1'b1;
    d_wr   = 1'b0;
    d_addr = 16'h0050;
    tick();
    chk("rstmid c1 mem_en", 64'(mem_en), 64'h1);
    tick();
    tick();
    rst   = 1'b1;
    d_req = 1'b0;
    tick();
    chk("rstmid c4 data", {i_rdata, d_rdata, mem_addr, mem_wdata}, 64'h0);
    chk("rstmid c4 ctl", 64'({i_ack, d_ack, mem_en, mem_wr, busy, owner}), 64'h0);
    rst = 1'b0;
    for (int c = 5; c <= 8; c++) begin
      tick();
      chk($sformatf("rstmid c%0d d_ack", c), 64'(d_ack), 64'h0);
      chk($sformatf("rstmid c%0d d_rdata", c), 64'(d_rdata), 64'h0);
      chk($sformatf("rstmid c%0d busy", c), 64'(busy), 64'h0);
    end

    // New I read after reset completes normally
    i_req  = 1'b1;
    i_addr = 16'h0060;
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk($sformatf("post c%0d mem_en", c), 64'(mem_en), 64'(c == 1));
      chk($sformatf("post c%0d i_ack", c), 64'(i_ack), 64'(c == 6));
      if (c == 6) begin
        chk("post i_rdata", 64'(i_rdata), 64'h6060);
        i_req = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter that shares one unified, fixed-latency, multi-cycle main memory between the CPU's instruction-fetch port and its data port. It sits between the fetch/memory stages of the `cpu` top level and the single backing memory, replacing the separate IM/DM instances. It serialises requests, drives the memory command for exactly one cycle, and captures read data. It then returns a one-cycle acknowledge to the winning requester.

## Interface
Parameters:
- `MEM_LAT`, default 4: cycles from the `mem_en` cycle to the `mem_rdata`-valid cycle. Legal range is ≥1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `i_req` in 1: fetch request (read only). Held until `i_ack`.
- `i_addr` in 16: fetch word address. Stable while `i_req` is high.
- `i_rdata` out 16: last fetched word (registered).
- `i_ack` out 1: one-cycle completion pulse for the fetch port.
- `d_req` in 1: data request. Held until `d_ack`.
- `d_wr` in 1: 1 = write, 0 = read. Stable while `d_req` is high.
- `d_addr` in 16: data address.
- `d_wdata` in 16: write data.
- `d_rdata` out 16: last data-read word (registered).
- `d_ack` out 1: one-cycle completion pulse for the data port.
- `mem_en` out 1: memory command strobe.
- `mem_wr` out 1: memory write enable. Only ever high together with `mem_en`.
- `mem_addr` out 16: memory address.
- `mem_wdata` out 16: memory write data.
- `mem_rdata` in 16: memory read data. Valid only in the cycle `MEM_LAT` cycles after the `mem_en` cycle.
- `busy` out 1: high whenever state ≠ IDLE.
- `owner` out 1: current or most recent grant (0 = I, 1 = D).

## Operation
- **FSM states:** IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE:**
  - Requests are sampled only in IDLE.
  - If exactly one `*_req` is high, grant it.
  - If both are high, grant the port that did *not* win the previous grant (round-robin). `owner` resets to 0, so the first tie goes to D.
  - On a grant: latch the port's address, write data and write flag into internal registers; set `owner`; go to ISSUE.
- **ISSUE** (1 cycle):
  - `mem_en`=1, `mem_wr` = latched write flag (always 0 for I).
  - `mem_addr` and `mem_wdata` come from the latched registers.
  - Load the down-counter with `MEM_LAT`; go to WAIT.
- **WAIT** (exactly `MEM_LAT` cycles):
  - Counter decrements each cycle.
  - In the cycle the counter equals 1: for a read, register `mem_rdata` into `i_rdata` or `d_rdata` according to `owner`. Then go to RESP.
  - Counter width is $clog2(MEM_LAT+1).
- **RESP** (1 cycle):
  - The owner's `*_ack`=1.
  - Return to IDLE unconditionally. Requests are not sampled in RESP, so a requester dropping `req` combinationally on `ack` is safe.
- **Writes:** ack at the same latency as reads. `d_rdata` is unchanged.
- **Output defaults:** `mem_en`, `mem_wr` and both acks are 0 in every state except as stated above. `mem_addr` and `mem_wdata` are 0 outside ISSUE.
- **Read-data hold:** `i_rdata` and `d_rdata` hold their value until the next read completes on their own port.
- **Reset:** takes priority over everything, including mid-transaction.
  - Next state is IDLE.
  - All outputs, `owner`, the counter and the latched registers go to 0.
  - An in-flight transaction is abandoned: no ack is issued, and a later `mem_rdata` is ignored.
- **Request drop:** a requester dropping `req` before its ack is a protocol violation. The transaction still completes and acks.

## Timing
- Cycle n is the cycle ending at edge n. A request is sampled high in IDLE at the end of cycle 0.
- Single transaction:
  - `mem_en` in cycle 1.
  - WAIT in cycles 2..`MEM_LAT`+1.
  - `mem_rdata` valid in cycle `MEM_LAT`+1.
  - ack and valid `*_rdata` in cycle `MEM_LAT`+2.
  - IDLE in cycle `MEM_LAT`+3.
- Back-to-back period is `MEM_LAT`+3 cycles (7 at the default).
- Reset values: `i_rdata`=`d_rdata`=`mem_addr`=`mem_wdata`=0x0000; `i_ack`=`d_ack`=`mem_en`=`mem_wr`=`busy`=`owner`=0.

## Test plan
- **Reset:** hold `rst` for 2 cycles with random requests → every output is 0 and `busy`=0 throughout.
- **Single I read:** `i_req` with `i_addr`=0x0010, memory model returns 0xA5A5 in cycle 5 → `mem_en`=1 and `mem_addr`=0x0010 in cycle 1 only; `i_ack`=1 in cycle 6 only with `i_rdata`=0xA5A5; `d_ack`=0 throughout.
- **D write:** `d_wr`=1, `d_addr`=0x0020, `d_wdata`=0x1234 → in cycle 1 `mem_en`=`mem_wr`=1, `mem_addr`=0x0020, `mem_wdata`=0x1234; `d_ack` in cycle 6; `d_rdata` unchanged.
- **Tie after reset:** `i_req` and `d_req` both high in cycle 0 and held until their acks → D is served first (`mem_en` cycle 1, `d_ack` cycle 6). I is sampled in cycle 7 (`mem_en` cycle 8, `i_ack` cycle 13).
- **Round-robin:** both requests re-asserted immediately after every ack for 4 grants → grant order D, I, D, I; no port waits more than one transaction.
- **Reset mid-transaction:** `rst` high in cycle 3 of a D read (`MEM_LAT`=4) → cycle 4 shows all outputs 0; no `d_ack`; `d_rdata` stays 0 despite `mem_rdata`=0xBEEF in cycle 5. A new I read started after reset completes normally with a 6-cycle ack.
